// File: rtl/pipe_seg_adder.sv
// Pipelined segmented adder/subtractor: one SEG-bit slice per stage, carry registered
// between stages, global stall enable driven by output backpressure.
module pipe_seg_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NSTG = WIDTH / SEG;

  generate
    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
      $error("pipe_seg_adder: WIDTH must be a positive multiple of SEG");
    end
  endgenerate

  logic             en;
  logic [NSTG:0]    vld;
  logic [NSTG:0]    cy;
  logic [WIDTH-1:0] opa  [NSTG];
  logic [WIDTH-1:0] opb  [NSTG];
  logic [WIDTH-1:0] res  [NSTG+1];
  logic [WIDTH-1:0] nres [NSTG];
  logic [NSTG-1:0]  ncy;
  logic [SEG:0]     seg_sum [NSTG];
  logic             nxt_ovf;
  logic             ovf_q;

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld[NSTG];
  assign s         = res[NSTG];
  assign co        = cy[NSTG];
  assign ovf       = ovf_q;

  // Stage k adds only slice k of the operands it holds; lower slices of res are already final.
  always_comb begin
    ncy = '0;
    for (int unsigned k = 0; k < NSTG; k++) begin
      seg_sum[k] = {1'b0, opa[k][k*SEG +: SEG]} + {1'b0, opb[k][k*SEG +: SEG]}
                   + (SEG+1)'(cy[k]);
      nres[k] = res[k];
      nres[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      ncy[k] = seg_sum[k][SEG];
    end
    // carry into MSB is a^b^r at the MSB; overflow is that XOR the carry out
    nxt_ovf = opa[NSTG-1][WIDTH-1] ^ opb[NSTG-1][WIDTH-1] ^ nres[NSTG-1][WIDTH-1]
              ^ ncy[NSTG-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      cy    <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < NSTG; k++) begin
        opa[k] <= '0;
        opb[k] <= '0;
      end
      for (int unsigned k = 0; k < NSTG + 1; k++) begin
        res[k] <= '0;
      end
    end else if (en) begin
      vld    <= {vld[NSTG-1:0], in_valid};
      opa[0] <= a;
      opb[0] <= sub ? ~b : b;
      cy[0]  <= sub | ci;
      res[0] <= '0;
      for (int unsigned k = 1; k < NSTG; k++) begin
        opa[k] <= opa[k-1];
        opb[k] <= opb[k-1];
      end
      for (int unsigned k = 0; k < NSTG; k++) begin
        res[k+1] <= nres[k];
        cy[k+1]  <= ncy[k];
      end
      ovf_q <= nxt_ovf;
    end
  end

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Bench for pipe_seg_adder at 16/4, 32/8 and 8/8: directed corner cases plus random
// streams with backpressure, checked against an arithmetic latency/result model.
module tb_pipe_seg_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        d16_iv, d16_ir, d16_ci, d16_sub, d16_ov, d16_or, d16_co, d16_ovf;
  logic [15:0] d16_a, d16_b, d16_s;
  logic        d32_iv, d32_ir, d32_ci, d32_sub, d32_ov, d32_or, d32_co, d32_ovf;
  logic [31:0] d32_a, d32_b, d32_s;
  logic        d8_iv, d8_ir, d8_ci, d8_sub, d8_ov, d8_or, d8_co, d8_ovf;
  logic [7:0]  d8_a, d8_b, d8_s;

  pipe_seg_adder #(.WIDTH(16), .SEG(4)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(d16_iv), .in_ready(d16_ir), .a(d16_a), .b(d16_b),
    .ci(d16_ci), .sub(d16_sub), .out_valid(d16_ov), .out_ready(d16_or), .s(d16_s),
    .co(d16_co), .ovf(d16_ovf));
  pipe_seg_adder #(.WIDTH(32), .SEG(8)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(d32_iv), .in_ready(d32_ir), .a(d32_a), .b(d32_b),
    .ci(d32_ci), .sub(d32_sub), .out_valid(d32_ov), .out_ready(d32_or), .s(d32_s),
    .co(d32_co), .ovf(d32_ovf));
  pipe_seg_adder #(.WIDTH(8), .SEG(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(d8_iv), .in_ready(d8_ir), .a(d8_a), .b(d8_b),
    .ci(d8_ci), .sub(d8_sub), .out_valid(d8_ov), .out_ready(d8_or), .s(d8_s),
    .co(d8_co), .ovf(d8_ovf));

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ovf;
    int          rem;
  } exp_t;

  exp_t        q [3][$];
  int          tests = 0;
  int          fails = 0;
  int unsigned wd   [3] = '{16, 32, 8};
  int          nstg [3] = '{4, 4, 1};
  logic        cur_iv [3], cur_ci [3], cur_sub [3], cur_or [3];
  logic [63:0] cur_a  [3], cur_b  [3];
  int          acc    [3] = '{0, 0, 0};
  int          pops   [3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Result from plain integer arithmetic and sign rules.
  function automatic exp_t model(input int unsigned w, input logic [63:0] av,
                                 input logic [63:0] bv, input logic c, input logic sb);
    exp_t e;
    longint unsigned m, ua, ub, full;
    logic sa, sbb, sr;
    m  = (64'd1 << w) - 64'd1;
    ua = av & m;
    ub = bv & m;
    if (!sb) begin
      full = ua + ub + 64'(c);
      e.s  = full & m;
      e.co = ((full >> w) & 64'd1) != 0;
    end else begin
      e.s  = (ua - ub) & m;
      e.co = (ua >= ub);
    end
    sa  = ua[w-1];
    sbb = ub[w-1];
    sr  = e.s[w-1];
    e.ovf = sb ? ((sa != sbb) && (sr != sa)) : ((sa == sbb) && (sr != sa));
    e.rem = 0;
    return e;
  endfunction

  task automatic drive(input int d, input logic v, input logic [63:0] av, input logic [63:0] bv,
                       input logic c, input logic sb, input logic r);
    cur_iv[d] = v; cur_a[d] = av; cur_b[d] = bv; cur_ci[d] = c; cur_sub[d] = sb; cur_or[d] = r;
    case (d)
      0: begin d16_iv = v; d16_a = av[15:0]; d16_b = bv[15:0]; d16_ci = c; d16_sub = sb; d16_or = r; end
      1: begin d32_iv = v; d32_a = av[31:0]; d32_b = bv[31:0]; d32_ci = c; d32_sub = sb; d32_or = r; end
      default: begin d8_iv = v; d8_a = av[7:0]; d8_b = bv[7:0]; d8_ci = c; d8_sub = sb; d8_or = r; end
    endcase
  endtask

  task automatic sample(input int d, output logic ov, output logic ir, output logic co_o,
                        output logic ovf_o, output logic [63:0] s_o);
    case (d)
      0: begin ov = d16_ov; ir = d16_ir; co_o = d16_co; ovf_o = d16_ovf; s_o = 64'(d16_s); end
      1: begin ov = d32_ov; ir = d32_ir; co_o = d32_co; ovf_o = d32_ovf; s_o = 64'(d32_s); end
      default: begin ov = d8_ov; ir = d8_ir; co_o = d8_co; ovf_o = d8_ovf; s_o = 64'(d8_s); end
    endcase
  endtask

  // Mid-cycle: compare outputs to the model, then advance the model across the next edge.
  task automatic observe(input int d);
    logic ov, ir, co_o, ovf_o, exp_ov, en;
    logic [63:0] s_o;
    exp_t e;
    sample(d, ov, ir, co_o, ovf_o, s_o);
    exp_ov = (q[d].size() > 0) && (q[d][0].rem == 0);
    en     = !exp_ov || cur_or[d];
    check($sformatf("w%0d out_valid", wd[d]), 64'(ov), 64'(exp_ov));
    check($sformatf("w%0d in_ready", wd[d]), 64'(ir), 64'(en));
    if (exp_ov) begin
      check($sformatf("w%0d s", wd[d]), s_o, q[d][0].s);
      check($sformatf("w%0d co", wd[d]), 64'(co_o), 64'(q[d][0].co));
      check($sformatf("w%0d ovf", wd[d]), 64'(ovf_o), 64'(q[d][0].ovf));
    end
    if (en) begin
      if (exp_ov && cur_or[d]) begin
        void'(q[d].pop_front());
        pops[d]++;
      end
      for (int i = 0; i < q[d].size(); i++)
        if (q[d][i].rem > 0) q[d][i].rem = q[d][i].rem - 1;
      if (cur_iv[d]) begin
        e = model(wd[d], cur_a[d], cur_b[d], cur_ci[d], cur_sub[d]);
        e.rem = nstg[d];
        q[d].push_back(e);
        acc[d]++;
      end
    end
  endtask

  task automatic single(input int d, input string tag, input logic [63:0] av,
                        input logic [63:0] bv, input logic c, input logic sb,
                        input logic [63:0] es, input logic eco, input logic eovf);
    logic ov, ir, co_o, ovf_o;
    logic [63:0] s_o;
    int lat;
    lat = -1;
    @(negedge clk); drive(d, 1'b1, av, bv, c, sb, 1'b1); #1; observe(d);
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      @(negedge clk); drive(d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1); #1;
      sample(d, ov, ir, co_o, ovf_o, s_o);
      if (ov) begin
        lat = i - 1;
        check({tag, " s"}, s_o, es);
        check({tag, " co"}, 64'(co_o), 64'(eco));
        check({tag, " ovf"}, 64'(ovf_o), 64'(eovf));
      end
      observe(d);
    end
    check({tag, " latency"}, 64'(lat), 64'(nstg[d]));
  endtask

  logic [15:0] va [10];
  logic [15:0] vb [10];
  int          nb, cyc, stalls, a0, p0;
  int          ra [3], rp [3];
  logic        r, ov, ir, co_o, ovf_o, busy;
  logic [63:0] s_o;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // reset state
    @(negedge clk); #1;
    check("reset out_valid", 64'(d16_ov), 64'd0);
    check("reset s", 64'(d16_s), 64'd0);
    check("reset co", 64'(d16_co), 64'd0);
    check("reset ovf", 64'(d16_ovf), 64'd0);
    check("reset w32 out_valid", 64'(d32_ov), 64'd0);
    check("reset w8 out_valid", 64'(d8_ov), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("empty in_ready", 64'(d16_ir), 64'd1);

    // directed arithmetic corners
    single(0, "ffff+1", 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0);
    single(0, "7fff+1", 64'h7FFF, 64'h0001, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1);
    single(0, "1234+1111+c", 64'h1234, 64'h1111, 1'b1, 1'b0, 64'h2346, 1'b0, 1'b0);
    single(0, "5-7", 64'h0005, 64'h0007, 1'b0, 1'b1, 64'hFFFE, 1'b0, 1'b0);
    single(0, "5-7 ci ignored", 64'h0005, 64'h0007, 1'b1, 1'b1, 64'hFFFE, 1'b0, 1'b0);
    single(0, "8000-1", 64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1);
    single(2, "w8 ff+1", 64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0);
    single(2, "w8 7f+1", 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1);
    single(1, "w32 carry chain", 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);

    // 10-beat stream with a 3-cycle output stall
    for (int i = 0; i < 10; i++) begin va[i] = 16'($urandom); vb[i] = 16'($urandom); end
    stalls = 0; cyc = 0; a0 = acc[0]; p0 = pops[0];
    while (!((acc[0] - a0) == 10 && q[0].size() == 0) && cyc < 100) begin
      nb = acc[0] - a0;
      r  = !(cyc >= 6 && cyc < 9);
      @(negedge clk);
      drive(0, nb < 10, 64'(va[nb < 10 ? nb : 0]), 64'(vb[nb < 10 ? nb : 0]), 1'b1,
            nb[0], r);
      #1;
      sample(0, ov, ir, co_o, ovf_o, s_o);
      if (ov && !r) stalls++;
      observe(0);
      cyc++;
    end
    check("stream results", 64'(pops[0] - p0), 64'd10);
    check("stream stall cycles", 64'(stalls), 64'd3);

    // reset with three beats in flight, the oldest waiting at the output
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 1'b1, 64'($urandom), 64'($urandom), 1'b0, 1'b0, 1'b0); #1;
      observe(0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0); #1; observe(0);
    end
    @(posedge clk); #2;
    check("prefill out_valid", 64'(d16_ov), 64'd1);
    rst_n = 1'b0; #1;
    check("async reset out_valid", 64'(d16_ov), 64'd0);
    check("async reset s", 64'(d16_s), 64'd0);
    check("async reset co", 64'(d16_co), 64'd0);
    for (int d = 0; d < 3; d++) q[d].delete();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1); #1; observe(0);
    end
    single(0, "post-reset 1+2", 64'h0001, 64'h0002, 1'b0, 1'b0, 64'h0003, 1'b0, 1'b0);

    // random traffic with random backpressure at 32/8 and 8/8
    for (int d = 1; d < 3; d++) begin ra[d] = acc[d]; rp[d] = pops[d]; end
    cyc = 0; busy = 1'b1;
    while (busy && cyc < 20000) begin
      @(negedge clk);
      for (int d = 1; d < 3; d++)
        drive(d, (acc[d] - ra[d] < 2000) && ($urandom_range(0, 3) != 0),
              {$urandom(), $urandom()}, {$urandom(), $urandom()},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0);
      #1;
      for (int d = 1; d < 3; d++) observe(d);
      busy = 1'b0;
      for (int d = 1; d < 3; d++)
        if (acc[d] - ra[d] < 2000 || q[d].size() != 0) busy = 1'b1;
      cyc++;
    end
    check("random w32 results", 64'(pops[1] - rp[1]), 64'd2000);
    check("random w8 results", 64'(pops[2] - rp[2]), 64'd2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
